// File: rtl/sum_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sum_pkg
//  Description : Shared types and constants for the chunk-serial adder family
//                (state encoding, ceil-log2 helper, default widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package sum_pkg;

   localparam int SUM_N = 16384;
   localparam int SUM_W = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      HOLD    = 2'd2
   } state_t;

   // Ceiling log2, never smaller than 1 so a counter always has a bit.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      if (r < 1) r = 1;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sum_chunk_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : sum_chunk_ctr
//  Description : Chunk index counter with clear, enable and last-chunk flag.
//                clear together with enable loads 1 (chunk 0 consumed in the
//                same cycle the count restarts). Wraps to 0 after CC-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module sum_chunk_ctr #(
   parameter int CC = 4,
   parameter int IW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          en_i,
   output logic [IW-1:0] idx_o,
   output logic          last_o
);

   logic [IW-1:0] idx_q;
   logic [IW-1:0] idx_d;

   assign last_o = (idx_q == IW'(CC - 1));
   assign idx_o  = idx_q;

   // Next index: restart, restart-and-consume, advance or wrap.
   always_comb begin
      idx_d = idx_q;
      if (clr_i && en_i) begin
         idx_d = IW'(1);
      end else if (clr_i) begin
         idx_d = '0;
      end else if (en_i) begin
         idx_d = last_o ? '0 : idx_q + IW'(1);
      end
   end

   // Index register, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) idx_q <= '0;
      else      idx_q <= idx_d;
   end

endmodule
`default_nettype wire

// File: rtl/sum_chunk_collect.sv
`default_nettype none
// ============================================================================
//  Module      : sum_chunk_collect
//  Description : Deserializes LSB-first W-bit sum digits into an N-bit result
//                and presents it through a valid/ready handshake. Flags digits
//                that arrive while no collection is open (sticky drop_err).
//                Optional running parity of accepted digits when the macro
//                SUM_COLLECT_PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module sum_chunk_collect
   import sum_pkg::*;
#(
   parameter int N = SUM_N,
   parameter int W = SUM_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      c_valid,
   input  logic [W-1:0]              c,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [N-1:0]              res,
   output logic                      busy,
   output logic [clog2(N/W)-1:0]     chunk_idx,
`ifdef SUM_COLLECT_PARITY_EN
   output logic                      parity,
`endif
   output logic                      drop_err
);

   localparam int CC = N / W;
   localparam int IW = clog2(CC);

   state_t        state_q, state_d;
   logic [N-1:0]  res_q, res_d;
   logic          drop_q, drop_d;
   logic          w_accept;
   logic          w_start_acc;
   logic          w_ctr_clr;
   logic          w_last;
   logic [IW-1:0] w_idx;
   logic [IW-1:0] w_slot;

   sum_chunk_ctr #(.CC(CC), .IW(IW)) u_ctr (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (w_ctr_clr),
      .en_i   (w_accept),
      .idx_o  (w_idx),
      .last_o (w_last)
   );

   // A restart that coincides with a digit stores that digit as chunk 0.
   assign w_slot = start ? '0 : w_idx;

   // Next-state, digit acceptance and sticky drop flag.
   always_comb begin
      state_d     = state_q;
      drop_d      = drop_q;
      w_accept    = 1'b0;
      w_start_acc = 1'b0;
      w_ctr_clr   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = COLLECT;
               w_ctr_clr   = 1'b1;
               w_start_acc = 1'b1;
            end else if (c_valid) begin
               drop_d = 1'b1;
            end
         end
         COLLECT: begin
            w_ctr_clr   = start;
            w_start_acc = start;
            w_accept    = c_valid;
            if (c_valid && !start && w_last) state_d = HOLD;
         end
         HOLD: begin
            if (c_valid) drop_d = 1'b1;
            if (res_ready) begin
               if (start) begin
                  state_d     = COLLECT;
                  w_ctr_clr   = 1'b1;
                  w_start_acc = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (w_start_acc) drop_d = 1'b0;
   end

   // Result write path: one digit slot per accepted digit.
   always_comb begin
      res_d = res_q;
      if (w_accept) res_d[int'(w_slot) * W +: W] = c;
   end

   // State, result and flag registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         res_q   <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         drop_q  <= drop_d;
      end
   end

`ifdef SUM_COLLECT_PARITY_EN
   logic par_q, par_d;

   // Running XOR of accepted digit bits, restarted by an accepted start.
   always_comb begin
      par_d = par_q;
      if (w_start_acc) par_d = 1'b0;
      if (w_accept)    par_d = par_d ^ (^c);
   end

   // Parity register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) par_q <= 1'b0;
      else      par_q <= par_d;
   end

   assign parity = par_q;
`endif

   assign res       = res_q;
   assign res_valid = (state_q == HOLD);
   assign busy      = (state_q == COLLECT);
   assign chunk_idx = w_idx;
   assign drop_err  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_sum_chunk_collect.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sum_chunk_collect
//  Description : Directed, table-driven bench for sum_chunk_collect at
//                N=16, W=4 (CC=4). Parity checks under SUM_COLLECT_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_chunk_collect;

   localparam int N  = 16;
   localparam int W  = 4;
   localparam int IW = 2;

   typedef struct {
      logic          start;
      logic          cv;
      logic [W-1:0]  c;
      logic          rdy;
      logic          e_rv;
      logic          e_busy;
      logic [IW-1:0] e_idx;
      logic [N-1:0]  e_res;
      logic          e_drop;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          c_valid;
   logic [W-1:0]  c;
   logic          res_valid;
   logic          res_ready;
   logic [N-1:0]  res;
   logic          busy;
   logic [IW-1:0] chunk_idx;
   logic          drop_err;
`ifdef SUM_COLLECT_PARITY_EN
   logic          parity;
`endif

   int total = 0;
   int bad   = 0;
   vec_t vec [0:63];
   int   nvec = 0;

   sum_chunk_collect #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .c_valid   (c_valid),
      .c         (c),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res       (res),
      .busy      (busy),
      .chunk_idx (chunk_idx),
`ifdef SUM_COLLECT_PARITY_EN
      .parity    (parity),
`endif
      .drop_err  (drop_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic s, input logic v, input logic [W-1:0] d, input logic r,
                      input logic erv, input logic eb, input logic [IW-1:0] ei,
                      input logic [N-1:0] er, input logic ed);
      vec[nvec] = '{s, v, d, r, erv, eb, ei, er, ed};
      nvec++;
   endtask

   task automatic drive(input logic s, input logic v, input logic [W-1:0] d, input logic r);
      @(negedge clk);
      start = s; c_valid = v; c = d; res_ready = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // start, cv, c, rdy | rv, busy, idx, res, drop
      // 1: plain collection
      add(1,0,4'h0,0, 0,1,0,16'h0000,0);
      add(0,1,4'h1,0, 0,1,1,16'h0001,0);
      add(0,1,4'h2,0, 0,1,2,16'h0021,0);
      add(0,1,4'h3,0, 0,1,3,16'h0321,0);
      add(0,1,4'h4,0, 1,0,0,16'h4321,0);
      add(0,0,4'h0,1, 0,0,0,16'h4321,0);
      // 2: stalls between chunks 1 and 2
      add(1,0,4'h0,0, 0,1,0,16'h4321,0);
      add(0,1,4'h1,0, 0,1,1,16'h4321,0);
      add(0,1,4'h2,0, 0,1,2,16'h4321,0);
      add(0,0,4'h0,0, 0,1,2,16'h4321,0);
      add(0,0,4'h0,0, 0,1,2,16'h4321,0);
      add(0,1,4'h3,0, 0,1,3,16'h4321,0);
      add(0,1,4'h4,0, 1,0,0,16'h4321,0);
      // 3: HOLD with stray digits, then release
      for (int k = 0; k < 10; k++) add(0,1,4'hF,0, 1,0,0,16'h4321,1);
      add(0,0,4'h0,1, 0,0,0,16'h4321,1);
      add(0,1,4'hF,0, 0,0,0,16'h4321,1);
      // 4: abort/restart with a digit on the restart cycle
      add(1,0,4'h0,0, 0,1,0,16'h4321,0);
      add(0,1,4'hA,0, 0,1,1,16'h432A,0);
      add(0,1,4'hB,0, 0,1,2,16'h43BA,0);
      add(1,1,4'h5,0, 0,1,1,16'h43B5,0);
      add(0,1,4'h6,0, 0,1,2,16'h4365,0);
      add(0,1,4'h7,0, 0,1,3,16'h4765,0);
      add(0,1,4'h8,0, 1,0,0,16'h8765,0);
      // start in HOLD: ignored without ready, direct restart with ready
      add(1,0,4'h0,0, 1,0,0,16'h8765,0);
      add(1,0,4'h0,1, 0,1,0,16'h8765,0);
      add(0,1,4'h9,0, 0,1,1,16'h8769,0);
      // res_ready outside HOLD has no effect
      add(0,0,4'h0,1, 0,1,1,16'h8769,0);

      rst = 1'b0; start = 0; c_valid = 0; c = '0; res_ready = 0;
      #2;
      chk("reset res_valid", 32'(res_valid), 0);
      chk("reset busy",      32'(busy), 0);
      chk("reset chunk_idx", 32'(chunk_idx), 0);
      chk("reset res",       32'(res), 0);
      chk("reset drop_err",  32'(drop_err), 0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < nvec; i++) begin
         drive(vec[i].start, vec[i].cv, vec[i].c, vec[i].rdy);
         chk($sformatf("row%0d res_valid", i), 32'(res_valid), 32'(vec[i].e_rv));
         chk($sformatf("row%0d busy", i),      32'(busy),      32'(vec[i].e_busy));
         chk($sformatf("row%0d chunk_idx", i), 32'(chunk_idx), 32'(vec[i].e_idx));
         chk($sformatf("row%0d res", i),       32'(res),       32'(vec[i].e_res));
         chk($sformatf("row%0d drop_err", i),  32'(drop_err),  32'(vec[i].e_drop));
      end

      // 5: asynchronous reset mid-collection, then a fresh operation
      drive(0, 1, 4'hA, 0);
      chk("pre-reset idx", 32'(chunk_idx), 2);
      chk("pre-reset res", 32'(res), 32'h87A9);
      drive(0, 1, 4'hF, 0);
      @(negedge clk);
      c_valid = 0;
      rst = 1'b0;
      #1;
      chk("midrst res_valid", 32'(res_valid), 0);
      chk("midrst busy",      32'(busy), 0);
      chk("midrst chunk_idx", 32'(chunk_idx), 0);
      chk("midrst res",       32'(res), 0);
      chk("midrst drop_err",  32'(drop_err), 0);
      @(negedge clk);
      rst = 1'b1;
      drive(1, 0, 4'h0, 0);
      for (int k = 0; k < 4; k++) drive(0, 1, 4'hF, 0);
      chk("ffff res",       32'(res), 32'hFFFF);
      chk("ffff res_valid", 32'(res_valid), 1);
      chk("ffff busy",      32'(busy), 0);
      drive(0, 0, 4'h0, 1);
      chk("ffff released", 32'(res_valid), 0);

`ifdef SUM_COLLECT_PARITY_EN
      // 6: parity over 1,3,0,8 -> 4 ones -> even
      drive(1, 0, 4'h0, 0);
      chk("par after start", 32'(parity), 0);
      drive(0, 1, 4'h1, 0);
      chk("par after 0x1", 32'(parity), 1);
      drive(0, 1, 4'h3, 0);
      drive(0, 1, 4'h0, 0);
      drive(0, 1, 4'h8, 0);
      chk("par final",     32'(parity), 0);
      chk("par res",       32'(res), 32'h8031);
      drive(0, 0, 4'h0, 0);
      chk("par held", 32'(parity), 0);
      drive(0, 0, 4'h0, 1);
`endif

      @(negedge clk);
      start = 0; c_valid = 0; res_ready = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
